aes_iter_decrypt: RTL and testbench

//  Iterative AES inverse cipher (FIPS-197): one round per clock, on-chip key expansion.

---
 rtl/aes_iter_decrypt.sv | 228 ++++++++++++++++++++++
 tb/tb_aes_iter_decrypt.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_decrypt.sv
// aes_iter_decrypt: iterative AES-128/192/256 inverse cipher. It runs one round per clock and
// expands the key on-chip, one 32-bit word per clock, into a round-key register file.
// Ports: clk, and reset (asynchronous, active-high). The job input is in_valid/in_ready/in/key,
// and a job is accepted only in IDLE. The plaintext output is out_valid/out_ready/out, and out
// is held until it is taken. busy is high during KEYEXP and ROUND.
// Latency from the accept edge to out_valid is 4(Nr+1)-Nk+Nr+1 edges. One job is in flight.
// Option AES_DEC_KEY_CACHE_EN keeps the last expanded key and skips KEYEXP when the key repeats.
module aes_iter_decrypt #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  input  logic [N-1:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out,
  output logic         busy
);
  localparam int NW = 4 * (Nr + 1);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  // Byte x of a table sits at bit offset (255-x)*8, which is {~x, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] x);
    return ISBOX[{~x, 3'b000} +: 8];
  endfunction

  // Multiply by x in GF(2^8). This also advances Rcon, so 0x80 wraps to 0x1b.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0]  a [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
    // Row i applies {0e,0b,0d,09} starting at column i. Each coefficient is a sum of x8/x4/x2/x1.
    for (int i = 0; i < 4; i++)
      r[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i]) ^
                       (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4]) ^
                       (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4]) ^
                       (x8[(i+3)%4] ^ a[(i+3)%4]);
    return r;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_ROUND, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [31:0]  w_q [NW];
  logic [5:0]   wi_q, wi_d;      // index of the key word being produced
  logic [2:0]   kc_q, kc_d;      // wi_q mod Nk
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   r_q, r_d;        // round-key index, counts down from Nr
  logic [127:0] s_q, s_d;
  logic         key_ld, w_we, hit;
  logic [31:0]  kx_prev, kx_sw_in, kx_sw, kx_word;
  logic [5:0]   rk_base;
  logic [127:0] rk, isr_isb, rnd_add, rnd_mix;

  // Key path: the 4 S-boxes are shared between the RotWord and the plain SubWord cases.
  always_comb begin
    kx_prev  = w_q[wi_q - 6'd1];
    kx_sw_in = (kc_q == 3'd0) ? {kx_prev[23:0], kx_prev[31:24]} : kx_prev;
    kx_sw    = {sbox(kx_sw_in[31:24]), sbox(kx_sw_in[23:16]),
                sbox(kx_sw_in[15:8]),  sbox(kx_sw_in[7:0])};
    if (kc_q == 3'd0)                 kx_word = kx_sw ^ {rcon_q, 24'h0};
    else if (Nk == 8 && kc_q == 3'd4) kx_word = kx_sw;
    else                              kx_word = kx_prev;
    kx_word = kx_word ^ w_q[wi_q - 6'(Nk)];
  end

  // Round datapath: InvShiftRows+InvSubBytes, then AddRoundKey, then InvMixColumns.
  always_comb begin
    rk_base = {r_q, 2'b00};
    rk      = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
    isr_isb = '0;
    rnd_mix = '0;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        isr_isb[127-8*(4*col+row) -: 8] = isbox(s_q[127-8*(4*((col-row+4)%4)+row) -: 8]);
    rnd_add = isr_isb ^ rk;
    for (int col = 0; col < 4; col++)
      rnd_mix[127-32*col -: 32] = inv_mix_col(rnd_add[127-32*col -: 32]);
  end

`ifdef AES_DEC_KEY_CACHE_EN
  logic [N-1:0] ckey_q;
  logic         cache_vld_q;

  assign hit = cache_vld_q && (key == ckey_q);

  // The cache is dropped as soon as a new key begins to overwrite w_q.
  // It becomes valid again only after the last word has been written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ckey_q      <= '0;
      cache_vld_q <= 1'b0;
    end else begin
      if (key_ld) begin
        ckey_q      <= key;
        cache_vld_q <= 1'b0;
      end else if (state_q == S_KEYEXP && wi_q == 6'(NW - 1)) begin
        cache_vld_q <= 1'b1;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wi_d    = wi_q;
    kc_d    = kc_q;
    rcon_d  = rcon_q;
    r_d     = r_q;
    s_d     = s_q;
    key_ld  = 1'b0;
    w_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          s_d    = in;
          r_d    = 4'(Nr);
          wi_d   = 6'(Nk);
          kc_d   = 3'd0;
          rcon_d = 8'h01;
          if (hit) begin
            state_d = S_ROUND;
          end else begin
            state_d = S_KEYEXP;
            key_ld  = 1'b1;
          end
        end
      end
      S_KEYEXP: begin
        w_we = 1'b1;
        wi_d = wi_q + 6'd1;
        kc_d = (kc_q == 3'(Nk - 1)) ? 3'd0 : kc_q + 3'd1;
        if (kc_q == 3'd0) rcon_d = xt(rcon_q);
        if (wi_q == 6'(NW - 1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        if (r_q == 4'(Nr)) begin
          s_d = s_q ^ rk;          // initial AddRoundKey
          r_d = r_q - 4'd1;
        end else if (r_q == 4'd0) begin
          s_d     = rnd_add;       // final round has no InvMixColumns
          state_d = S_DONE;
        end else begin
          s_d = rnd_mix;
          r_d = r_q - 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wi_q    <= 6'(Nk);
      kc_q    <= 3'd0;
      rcon_q  <= 8'h01;
      r_q     <= '0;
      s_q     <= '0;
      for (int j = 0; j < NW; j++) w_q[j] <= '0;
    end else begin
      state_q <= state_d;
      wi_q    <= wi_d;
      kc_q    <= kc_d;
      rcon_q  <= rcon_d;
      r_q     <= r_d;
      s_q     <= s_d;
      if (key_ld) begin
        for (int j = 0; j < Nk; j++) w_q[j] <= key[N-1-32*j -: 32];
      end else if (w_we) begin
        w_q[wi_q] <= kx_word;
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_KEYEXP) || (state_q == S_ROUND);
  // Intermediate round state is not exposed; out carries data only while it is valid.
  assign out       = out_valid ? s_q : '0;

endmodule

// File: tb/tb_aes_iter_decrypt.sv
// tb_aes_iter_decrypt: three engines (AES-128/192/256) on one clock and reset.
// The reference model is a forward AES encryptor that builds its S-box from GF(2^8) arithmetic.
// Plaintext is encrypted by the model, fed to the engine, and the engine must return the plaintext.
module tb_aes_iter_decrypt;
  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   iv, ordy;
  wire  [2:0]   ir, ov, bsy;
  logic [127:0] ct_b [3];
  logic [255:0] key_b [3];
  wire  [127:0] pt_b [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sb [256];
  logic [7:0]   isb [256];
  logic [127:0] exp_pt [3];
  bit           exp_pend [3];
  bit           cval [3];
  logic [255:0] ckey [3];

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KREV = 256'h0f0e0d0c0b0a09080706050403020100;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GNK = 4 + 2 * g;
    aes_iter_decrypt #(.N(32 * GNK), .Nr(GNK + 6), .Nk(GNK)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in        (ct_b[g]),
      .key       (key_b[g][32*GNK-1:0]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out       (pt_b[g]),
      .busy      (bsy[g])
    );
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic int nk_of(input int d); return 4 + 2 * d; endfunction
  function automatic int nr_of(input int d); return 10 + 2 * d; endfunction
  function automatic int full_lat(input int d);
    return 4 * (nr_of(d) + 1) - nk_of(d) + nr_of(d) + 1;
  endfunction
  function automatic logic [255:0] kmask(input int d);
    return {256{1'b1}} >> (256 - 32 * nk_of(d));
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int exp_lat(input int d, input logic [255:0] k);
`ifdef AES_DEC_KEY_CACHE_EN
    if (cval[d] && ckey[d] == k) return nr_of(d) + 1;
`endif
    return full_lat(d);
  endfunction

  // Forward cipher (FIPS-197). The key is right-aligned in kv, so word 0 is the top key word.
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [255:0] kv, input int nk);
    logic [31:0]  w [60];
    logic [7:0]   st [16];
    logic [7:0]   tm [16];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] res;
    int           nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = kv[32*(nk-1-i) +: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int k = 0; k < 16; k++) st[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) tm[k] = sb[st[(k%4) + 4*(((k/4) + (k%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        if (r < nr) begin
          st[4*c]   = xt(tm[4*c]) ^ xt(tm[4*c+1]) ^ tm[4*c+1] ^ tm[4*c+2] ^ tm[4*c+3];
          st[4*c+1] = tm[4*c] ^ xt(tm[4*c+1]) ^ xt(tm[4*c+2]) ^ tm[4*c+2] ^ tm[4*c+3];
          st[4*c+2] = tm[4*c] ^ tm[4*c+1] ^ xt(tm[4*c+2]) ^ xt(tm[4*c+3]) ^ tm[4*c+3];
          st[4*c+3] = xt(tm[4*c]) ^ tm[4*c] ^ tm[4*c+1] ^ tm[4*c+2] ^ xt(tm[4*c+3]);
        end else begin
          for (int j = 0; j < 4; j++) st[4*c+j] = tm[4*c+j];
        end
      end
      for (int k = 0; k < 16; k++) st[k] ^= w[4*r + k/4][31-8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = st[k];
    return res;
  endfunction

  // Checker: the engine must hold the model plaintext whenever out_valid is high.
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        if (bsy[d]) chk("in_ready_while_busy", ir[d], 1'b0);
        if (ov[d]) begin
          if (exp_pend[d]) chk("out_vs_model", pt_b[d], exp_pt[d]);
          else             chk("unexpected_out_valid", ov[d], 1'b0);
        end
      end
    end
  end

  task automatic accept(input int d, input logic [127:0] pt, input logic [255:0] k, output int lat_exp);
    int w = 0;
    @(negedge clk);
    while (!ir[d] && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_accept", ir[d], 1'b1);
    lat_exp  = exp_lat(d, k);
    iv[d]    = 1'b1;
    ct_b[d]  = aes_enc(pt, k, nk_of(d));
    key_b[d] = k;
    @(posedge clk);
    #1;
    iv[d]       = 1'b0;
    exp_pt[d]   = pt;
    exp_pend[d] = 1'b1;
    if (lat_exp == full_lat(d)) begin
      cval[d] = 1'b0;
      ckey[d] = k;
    end
  endtask

  task automatic run_job(input int d, input logic [127:0] pt, input logic [255:0] k,
                         input int hold, input bit noisy, output int lat);
    int lat_exp;
    accept(d, pt, k, lat_exp);
    lat = 0;
    if (noisy) iv[d] = 1'b1;
    while (lat < 200) begin
      if (noisy) begin
        ct_b[d]  = rnd128();
        key_b[d] = {rnd128(), rnd128()} & kmask(d);
      end
      @(posedge clk);
      #1;
      lat++;
      if (ov[d]) break;
    end
    iv[d] = 1'b0;
    chk("latency", lat, lat_exp);
    if (ov[d]) begin
      cval[d] = 1'b1;
      chk("out_first", pt_b[d], pt);
      chk("in_ready_in_done", ir[d], 1'b0);
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      chk("out_valid_held", ov[d], 1'b1);
      chk("out_held", pt_b[d], pt);
      ordy[d] = 1'b1;
      @(posedge clk);
      #1;
      ordy[d] = 1'b0;
      chk("out_valid_after_take", ov[d], 1'b0);
      chk("in_ready_after_take", ir[d], 1'b1);
    end
    exp_pend[d] = 1'b0;
  endtask

  task automatic reset_mid(input int d, input logic [127:0] pt, input logic [255:0] k, input bit in_round);
    int le, edges;
    accept(d, pt, k, le);
    edges = in_round ? (le - nr_of(d) - 1) + 3 : 10;
    repeat (edges) @(posedge clk);
    #1;
    chk("busy_before_reset", bsy[d], 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_out_valid", ov[d], 1'b0);
    chk("rst_out", pt_b[d], 128'h0);
    chk("rst_busy", bsy[d], 1'b0);
    for (int dd = 0; dd < 3; dd++) begin
      cval[dd]     = 1'b0;
      exp_pend[dd] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", ir[d], 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [255:0] k, last_k;
    logic [7:0] b, inv;
    reset = 1'b1;
    iv    = '0;
    ordy  = '0;
    for (int d = 0; d < 3; d++) begin
      ct_b[d] = '0; key_b[d] = '0; exp_pt[d] = '0;
      exp_pend[d] = 1'b0; cval[d] = 1'b0; ckey[d] = '0;
    end
    // S-box from the multiplicative inverse followed by the affine map.
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      for (int s = 0; s < 4; s++) begin
        inv = {inv[6:0], inv[7]};
        b   = b ^ inv;
      end
      sb[x] = b ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);

    chk("model_sbox_00", sb[0], 8'h63);
    chk("model_sbox_53", sb[8'h53], 8'hed);
    chk("model_isbox_00", isb[0], 8'h52);
    chk("model_enc128", aes_enc(PT, K128, 4), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("model_enc192", aes_enc(PT, K192, 6), 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    chk("model_enc256", aes_enc(PT, K256, 8), 128'h8ea2b7ca516745bfeafc49904b496089);

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_out_valid", ov[d], 1'b0);
      chk("reset_out", pt_b[d], 128'h0);
      chk("reset_busy", bsy[d], 1'b0);
    end
    reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk("reset_in_ready", ir[d], 1'b1);

    // Known-answer jobs with fixed latencies
    run_job(0, PT, K128, 0, 1'b0, lat);  chk("t1_lat", lat, 51);
    run_job(1, PT, K192, 0, 1'b0, lat);  chk("t2_lat192", lat, 59);
    run_job(2, PT, K256, 0, 1'b0, lat);  chk("t2_lat256", lat, 67);

    // Repeated key, then a different key
    run_job(0, PT, K128, 0, 1'b0, lat);
`ifdef AES_DEC_KEY_CACHE_EN
    chk("t5_lat_repeat", lat, 11);
`else
    chk("t5_lat_repeat", lat, 51);
`endif
    run_job(0, PT, KREV, 0, 1'b0, lat);  chk("t5_lat_newkey", lat, 51);

    // Back-pressure for 20 cycles
    run_job(0, PT, K128, 20, 1'b0, lat);

    // Reset during KEYEXP and during ROUND, each followed by a clean job
    reset_mid(0, rnd128(), {rnd128(), rnd128()} & kmask(0), 1'b0);
    run_job(0, PT, K128, 0, 1'b0, lat);  chk("t4_lat_after_kx_reset", lat, 51);
    reset_mid(0, PT, K128, 1'b1);
    run_job(0, PT, K128, 0, 1'b0, lat);  chk("t4_lat_after_rnd_reset", lat, 51);

    // in_valid held with changing in/key while busy
    run_job(1, PT, K192, 1, 1'b1, lat);

    // Random jobs, with keys sometimes repeated
    for (int d = 0; d < 3; d++) begin
      last_k = '0;
      for (int j = 0; j < 6; j++) begin
        k = (j > 0 && $urandom_range(0, 1) == 1) ? last_k : ({rnd128(), rnd128()} & kmask(d));
        last_k = k;
        run_job(d, rnd128(), k, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), lat);
      end
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
